branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencer for control-flow resolution in the Execute stage of the Buraq-mini RV32IM pipeline. It evaluates conditional branches, JAL and JALR, computes the target, and presents a registered PC redirect to the fetch unit over a valid/ready handshake. It then holds the IF/ID and ID/EX flushes for the required number of cycles and keeps resolution statistics. Static not-taken policy: only taken branches and jumps cause a redirect.

## Interface
- DataWidth, 32, width of PC, operands, immediate and counters
- FlushCycles, 2, cycles of IF/ID flush after the redirect handshake (legal range 1..15)

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX holds a valid control-flow instruction this cycle
- ex_is_branch  input  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- ex_is_jal  input  1  JAL
- ex_is_jalr  input  1  JALR
- ex_func3  input  3  branch funct3
- ex_src1, ex_src2  input  DataWidth  rs1/rs2 operand values
- ex_pc  input  DataWidth  PC of the EX instruction
- ex_imm  input  DataWidth  sign-extended immediate
- redirect_ready  input  1  fetch accepts the redirect
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  DataWidth  new fetch address (registered)
- flush_if_id  output  1  squash the IF/ID register
- flush_id_ex  output  1  squash the ID/EX register
- misalign_exc  output  1  one-cycle pulse: taken target not word aligned
- misalign_tval  output  DataWidth  offending target, valid with misalign_exc
- branch_count  output  DataWidth  conditional branches resolved
- taken_count  output  DataWidth  conditional branches taken

## Operation
- Event accepted only on a rising edge in IDLE with ex_valid=1. Type priority when several flags are set: jal > jalr > branch. ex_valid with no flag set is ignored.
- Taken rule: jal/jalr always taken. Branch funct3:
  - 000: src1==src2
  - 001: !=
  - 100: signed <
  - 101: signed >=
  - 110: unsigned <
  - 111: unsigned >=
  - 010/011: not taken
- Target: jal and branch use ex_pc+ex_imm. jalr uses (ex_src1+ex_imm) with bit 0 cleared. Addition is modulo 2^DataWidth; wrap-around is legal.
- Taken with target[1:0]!=0: misalign_exc=1 and misalign_tval=target for one cycle. No redirect is issued and the state stays IDLE.
- Counters: branch_count increments on every accepted branch, taken or not (including 010/011). taken_count increments on accepted taken branches, including misaligned ones. Jumps are not counted. Both counters wrap at 2^DataWidth.
- FSM states:
  - IDLE: outputs 0. Accepted event that is taken and aligned → REDIRECT, with redirect_pc latched.
  - REDIRECT: redirect_valid=1, flush_if_id=1, flush_id_ex=1. On redirect_valid&&redirect_ready → FLUSH, with the counter loaded to FlushCycles-1. Otherwise stay.
  - FLUSH: flush_if_id=1, flush_id_ex=0, redirect_valid=0. When the counter reaches 0 → IDLE, otherwise decrement.
- ex_valid is ignored in REDIRECT and FLUSH, because those are wrong-path instructions. Counters do not change in those states.
- redirect_pc is stable and redirect_valid never drops while waiting for ready.

## Timing
- Reset (async assert, any state): IDLE, all outputs 0, redirect_pc=0, counters=0, flush counter=0. Reset in REDIRECT/FLUSH drops redirect and flushes immediately.
- Taken event accepted at edge N:
  - redirect_valid and both flushes are high from cycle N+1.
  - With redirect_ready=1 in cycle N+1, the handshake completes at edge N+2.
  - flush_if_id stays high for cycles N+2 .. N+1+FlushCycles.
  - IDLE from cycle N+2+FlushCycles. The next event can be accepted at the end of that cycle.
- Each cycle redirect_ready stays low extends REDIRECT by one cycle.
- misalign_exc is registered: high in cycle N+1 only. Counters update at edge N.
- Not-taken branch: no outputs change except counters; back-to-back accepts every cycle are allowed.

## Test plan
- BEQ, src1=src2=5, pc=0x100, imm=0x20, ready=1: redirect_pc=0x120 for 1 cycle, then flush_if_id 2 cycles, then IDLE. branch_count=1, taken_count=1.
- BLT src1=0xFFFFFFFF, src2=1 → taken. BLTU with the same operands → not taken. Check no redirect on the BLTU and branch_count=2, taken_count=1.
- JALR src1=0x1003, imm=0 → target 0x1002 (bit 0 cleared): misalign_exc pulse with tval=0x1002, no redirect. Then JAL pc=0x200, imm=-8 → redirect_pc=0x1F8.
- Redirect with ready held low 3 cycles: redirect_valid and redirect_pc are stable for 4 cycles, and ex_valid pulses in that window do not change the counters.
- Hold funct3 010 with ex_valid for 10 cycles: branch_count=10, taken_count=0, no redirect. Then pc=0xFFFFFFF0, imm=0x20 taken → redirect_pc=0x10 (wrap).
- Assert rst_n=0 mid-REDIRECT and mid-FLUSH: all outputs and counters read 0 immediately. Release reset, then a fresh branch resolves normally.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage control-flow resolver: evaluates branches/JAL/JALR, issues a
// registered fetch redirect over valid/ready, then sequences pipeline flushes.
module branch_redirect_ctrl #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned FlushCycles = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic [2:0]           ex_func3,
    input  logic [DataWidth-1:0] ex_src1,
    input  logic [DataWidth-1:0] ex_src2,
    input  logic [DataWidth-1:0] ex_pc,
    input  logic [DataWidth-1:0] ex_imm,
    input  logic                 redirect_ready,
    output logic                 redirect_valid,
    output logic [DataWidth-1:0] redirect_pc,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 misalign_exc,
    output logic [DataWidth-1:0] misalign_tval,
    output logic [DataWidth-1:0] branch_count,
    output logic [DataWidth-1:0] taken_count
);

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    localparam logic [3:0] FlushLoad = 4'(FlushCycles - 1);

    state_t               state;
    logic [3:0]           flush_cnt;
    logic                 sel_jal, sel_jalr, sel_br;
    logic                 br_taken, taken, accept, misaligned;
    logic [DataWidth-1:0] target;

    // Flag priority: jal > jalr > branch.
    always_comb begin
        sel_jal  = ex_is_jal;
        sel_jalr = !ex_is_jal && ex_is_jalr;
        sel_br   = !ex_is_jal && !ex_is_jalr && ex_is_branch;
    end

    always_comb begin
        br_taken = 1'b0;
        case (ex_func3)
            3'b000:  br_taken = (ex_src1 == ex_src2);
            3'b001:  br_taken = (ex_src1 != ex_src2);
            3'b100:  br_taken = ($signed(ex_src1) <  $signed(ex_src2));
            3'b101:  br_taken = ($signed(ex_src1) >= $signed(ex_src2));
            3'b110:  br_taken = (ex_src1 <  ex_src2);
            3'b111:  br_taken = (ex_src1 >= ex_src2);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        if (sel_jalr)
            target = (ex_src1 + ex_imm) & ~DataWidth'(1);
        else
            target = ex_pc + ex_imm;
        taken      = sel_jal || sel_jalr || (sel_br && br_taken);
        misaligned = (target[1:0] != 2'b00);
        accept     = (state == IDLE) && ex_valid && (sel_jal || sel_jalr || sel_br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            misalign_exc   <= 1'b0;
            misalign_tval  <= '0;
            branch_count   <= '0;
            taken_count    <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_br)
                            branch_count <= branch_count + 1'b1;
                        if (sel_br && br_taken)
                            taken_count <= taken_count + 1'b1;
                        if (taken && misaligned) begin
                            misalign_exc  <= 1'b1;
                            misalign_tval <= target;
                        end else if (taken) begin
                            state          <= REDIRECT;
                            redirect_pc    <= target;
                            redirect_valid <= 1'b1;
                            flush_if_id    <= 1'b1;
                            flush_id_ex    <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= FLUSH;
                        flush_cnt      <= FlushLoad;
                        redirect_valid <= 1'b0;
                        flush_id_ex    <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state       <= IDLE;
                        flush_if_id <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    flush_if_id    <= 1'b0;
                    flush_id_ex    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_branch_redirect_ctrl;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_func3;
    logic [31:0] ex_src1, ex_src2, ex_pc, ex_imm;
    logic        redirect_ready;
    logic        redirect_valid, flush_if_id, flush_id_ex, misalign_exc;
    logic [31:0] redirect_pc, misalign_tval, branch_count, taken_count;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.DataWidth(32), .FlushCycles(FC)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_func3(ex_func3),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .misalign_exc(misalign_exc), .misalign_tval(misalign_tval),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    typedef struct {
        bit v, br, jal, jalr;
        bit [2:0] f3;
        bit [31:0] s1, s2, pc, imm;
        bit rdy;
    } in_t;

    typedef struct {
        in_t i;
        bit rv, fif, fie, mis;
        bit [31:0] rpc, tval, bc, tc;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model: pending redirect + remaining flush cycles + counters.
    bit        m_rv, m_mis;
    bit [31:0] m_pc, m_tval, m_bc, m_tc;
    int        m_left;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(bit v, bit [1:0] kind, bit [2:0] f3, bit [31:0] s1,
                               bit [31:0] s2, bit [31:0] pc, bit [31:0] imm, bit rdy);
        in_t r;
        r.v = v; r.br = (kind == 2'd1); r.jal = (kind == 2'd2); r.jalr = (kind == 2'd3);
        r.f3 = f3; r.s1 = s1; r.s2 = s2; r.pc = pc; r.imm = imm; r.rdy = rdy;
        return r;
    endfunction

    function automatic vec_t row(in_t i, bit rv, bit [31:0] rpc, bit fif, bit fie,
                                 bit mis, bit [31:0] tval, bit [31:0] bc, bit [31:0] tc);
        vec_t r;
        r.i = i; r.rv = rv; r.rpc = rpc; r.fif = fif; r.fie = fie;
        r.mis = mis; r.tval = tval; r.bc = bc; r.tc = tc;
        return r;
    endfunction

    function automatic bit cond_taken(bit [2:0] f3, bit [31:0] a, bit [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return longint'(a) < longint'(b);
            3'd7: return longint'(a) >= longint'(b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_rv = 0; m_mis = 0; m_pc = 0; m_tval = 0; m_bc = 0; m_tc = 0; m_left = 0;
    endtask

    task automatic model_edge(input in_t i);
        bit tk;
        bit [31:0] tgt;
        m_mis = 0;
        if (m_rv) begin
            if (i.rdy) begin
                m_rv = 0;
                m_left = FC;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (i.v && (i.jal || i.jalr || i.br)) begin
            if (i.jal) begin
                tk = 1; tgt = i.pc + i.imm;
            end else if (i.jalr) begin
                tk = 1; tgt = (i.s1 + i.imm) & 32'hFFFF_FFFE;
            end else begin
                tk = cond_taken(i.f3, i.s1, i.s2); tgt = i.pc + i.imm;
                m_bc++;
                if (tk) m_tc++;
            end
            if (tk && (tgt % 4 != 0)) begin
                m_mis = 1; m_tval = tgt;
            end else if (tk) begin
                m_rv = 1; m_pc = tgt;
            end
        end
    endtask

    task automatic drive(input in_t i);
        ex_valid = i.v; ex_is_branch = i.br; ex_is_jal = i.jal; ex_is_jalr = i.jalr;
        ex_func3 = i.f3; ex_src1 = i.s1; ex_src2 = i.s2; ex_pc = i.pc; ex_imm = i.imm;
        redirect_ready = i.rdy;
    endtask

    task automatic cycle(input in_t i);
        drive(i);
        @(posedge clk);
        model_edge(i);
        #1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(m_rv));
        chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(m_rv || m_left > 0));
        chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(m_rv));
        chk({tag, ".misalign_exc"}, 32'(misalign_exc), 32'(m_mis));
        chk({tag, ".branch_count"}, branch_count, m_bc);
        chk({tag, ".taken_count"}, taken_count, m_tc);
        if (m_rv) chk({tag, ".redirect_pc"}, redirect_pc, m_pc);
        if (m_mis) chk({tag, ".misalign_tval"}, misalign_tval, m_tval);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 0);
        chk({tag, ".redirect_pc"}, redirect_pc, 0);
        chk({tag, ".flush_if_id"}, 32'(flush_if_id), 0);
        chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 0);
        chk({tag, ".misalign_exc"}, 32'(misalign_exc), 0);
        chk({tag, ".misalign_tval"}, misalign_tval, 0);
        chk({tag, ".branch_count"}, branch_count, 0);
        chk({tag, ".taken_count"}, taken_count, 0);
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    in_t idle1, idle0, bq, r;

    initial begin
        idle1 = mk(0, 0, 0, 0, 0, 0, 0, 1);
        idle0 = mk(0, 0, 0, 0, 0, 0, 0, 0);
        bq    = mk(1, 1, 3'd0, 32'h7, 32'h7, 32'h40, 32'h10, 0);

        // BEQ taken, then flush drain
        tbl.push_back(row(mk(1, 1, 3'd0, 5, 5, 32'h100, 32'h20, 1), 1, 32'h120, 1, 1, 0, 0, 1, 1));
        tbl.push_back(row(idle1, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(row(idle1, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(row(idle1, 0, 0, 0, 0, 0, 0, 1, 1));
        // BLT signed taken, BLTU same operands not taken
        tbl.push_back(row(mk(1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1), 1, 32'h340, 1, 1, 0, 0, 2, 2));
        tbl.push_back(row(idle1, 0, 0, 1, 0, 0, 0, 2, 2));
        tbl.push_back(row(idle1, 0, 0, 1, 0, 0, 0, 2, 2));
        tbl.push_back(row(idle1, 0, 0, 0, 0, 0, 0, 2, 2));
        tbl.push_back(row(mk(1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1), 0, 0, 0, 0, 0, 0, 3, 2));
        // JALR misaligned target, then JAL with negative offset and ready held low
        tbl.push_back(row(mk(1, 3, 0, 32'h1003, 0, 32'h500, 0, 1), 0, 0, 0, 0, 1, 32'h1002, 3, 2));
        tbl.push_back(row(mk(1, 2, 0, 0, 0, 32'h200, 32'hFFFF_FFF8, 0), 1, 32'h1F8, 1, 1, 0, 0, 3, 2));
        tbl.push_back(row(mk(1, 1, 3'd0, 9, 9, 32'h0, 32'h8, 0), 1, 32'h1F8, 1, 1, 0, 0, 3, 2));
        tbl.push_back(row(mk(1, 1, 3'd0, 9, 9, 32'h0, 32'h8, 0), 1, 32'h1F8, 1, 1, 0, 0, 3, 2));
        tbl.push_back(row(mk(1, 1, 3'd1, 9, 3, 32'h0, 32'h8, 0), 1, 32'h1F8, 1, 1, 0, 0, 3, 2));
        tbl.push_back(row(mk(1, 1, 3'd0, 9, 9, 32'h0, 32'h8, 1), 0, 0, 1, 0, 0, 0, 3, 2));
        tbl.push_back(row(mk(1, 1, 3'd0, 9, 9, 32'h0, 32'h8, 1), 0, 0, 1, 0, 0, 0, 3, 2));
        tbl.push_back(row(idle1, 0, 0, 0, 0, 0, 0, 3, 2));

        model_reset();
        do_reset();

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].i);
            chk($sformatf("tbl%0d.redirect_valid", k), 32'(redirect_valid), 32'(tbl[k].rv));
            chk($sformatf("tbl%0d.flush_if_id", k), 32'(flush_if_id), 32'(tbl[k].fif));
            chk($sformatf("tbl%0d.flush_id_ex", k), 32'(flush_id_ex), 32'(tbl[k].fie));
            chk($sformatf("tbl%0d.misalign_exc", k), 32'(misalign_exc), 32'(tbl[k].mis));
            chk($sformatf("tbl%0d.branch_count", k), branch_count, tbl[k].bc);
            chk($sformatf("tbl%0d.taken_count", k), taken_count, tbl[k].tc);
            if (tbl[k].rv) chk($sformatf("tbl%0d.redirect_pc", k), redirect_pc, tbl[k].rpc);
            if (tbl[k].mis) chk($sformatf("tbl%0d.misalign_tval", k), misalign_tval, tbl[k].tval);
            compare_model($sformatf("tblmodel%0d", k));
        end

        // Ten back-to-back funct3=010 branches, then a taken branch whose target wraps
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(mk(1, 1, 3'd2, 4, 4, 32'h80, 32'h40, 1));
            compare_model("f3_010");
        end
        chk("f3_010.branch_count", branch_count, 10);
        chk("f3_010.taken_count", taken_count, 0);
        cycle(mk(1, 1, 3'd0, 1, 1, 32'hFFFF_FFF0, 32'h20, 0));
        chk("wrap.redirect_valid", 32'(redirect_valid), 1);
        chk("wrap.redirect_pc", redirect_pc, 32'h10);
        compare_model("wrap");
        for (int k = 0; k < 4; k++) begin
            cycle(idle1);
            compare_model("wrap_drain");
        end

        // Reset in the middle of REDIRECT
        cycle(mk(1, 1, 3'd0, 1, 1, 32'h600, 32'h20, 0));
        compare_model("pre_rst_redirect");
        cycle(idle0);
        chk("mid_redirect.valid_before", 32'(redirect_valid), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("rst_in_redirect");
        #2 rst_n = 1'b1;
        // Reset in the middle of FLUSH
        cycle(mk(1, 1, 3'd5, 8, 2, 32'h700, 32'h4, 1));
        compare_model("pre_rst_flush");
        cycle(idle1);
        chk("mid_flush.fif_before", 32'(flush_if_id), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("rst_in_flush");
        #2 rst_n = 1'b1;
        cycle(mk(1, 1, 3'd1, 3, 4, 32'h800, 32'h100, 1));
        chk("post_rst.redirect_pc", redirect_pc, 32'h900);
        chk("post_rst.branch_count", branch_count, 1);
        compare_model("post_rst");
        for (int k = 0; k < 4; k++) begin
            cycle(idle1);
            compare_model("post_rst_drain");
        end

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            r.v    = ($urandom_range(0, 9) < 7);
            r.br   = $urandom_range(0, 1);
            r.jal  = ($urandom_range(0, 5) == 0);
            r.jalr = ($urandom_range(0, 5) == 0);
            r.f3   = 3'($urandom_range(0, 7));
            r.s1   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            r.s2   = ($urandom_range(0, 3) == 0) ? r.s1 :
                     (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4)));
            r.pc   = $urandom & 32'hFFFF_FFFC;
            r.imm  = $urandom;
            if ($urandom_range(0, 3) != 0) r.imm = r.imm & 32'hFFFF_FFFC;
            if (r.jalr && $urandom_range(0, 1) != 0) r.s1 = r.s1 & 32'hFFFF_FFFC;
            r.rdy  = ($urandom_range(0, 9) < 6);
            cycle(r);
            compare_model($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
